// File: rtl/mux_sel_rr_gen_pkg.sv
// Shared sizing, select type and FSM state encoding for the mux select generator.
package mux_pkg;
  localparam int MUX_DEPTH = 16;
  localparam int MUX_SEL_W = 4;

  typedef logic [MUX_SEL_W-1:0] mux_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } mux_sel_state_e;
endpackage

// File: rtl/mux_sel_rr_gen_pick.sv
// Combinational round-robin search: first set req bit after ptr, wrapping modulo DEPTH.
module mux_rr_pick #(
  parameter int DEPTH = 16,
  parameter int SEL_W = 4
) (
  input  logic [DEPTH-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  assign found = |req;

  // Walk from lowest to highest priority so the last hit written is the winner.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + 1 + i) % DEPTH]) begin
        idx = SEL_W'((int'(ptr) + 1 + i) % DEPTH);
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_gen.sv
// Round-robin select generator for the data mux: registered one-hot grant + binary sel, valid/ready held.
// Optional MUX_SEL_LOCK_EN adds a lock input that re-grants the same requester at a transfer.
module mux_sel_rr_gen
  import mux_pkg::*;
#(
  parameter int DEPTH = MUX_DEPTH,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] req,
  input  logic             out_ready,
`ifdef MUX_SEL_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic [DEPTH-1:0] grant,
  output logic             busy
);

  mux_sel_state_e   r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [DEPTH-1:0] r_grant;

  logic [SEL_W-1:0] w_search_ptr;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic [DEPTH-1:0] w_idx_oh;
  logic             w_relock;

  // At a transfer the pointer becomes the current sel, so search from it directly.
  assign w_search_ptr = (r_state == GRANT) ? r_sel : r_ptr;

  mux_rr_pick #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (w_search_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_idx_oh = {{(DEPTH-1){1'b0}}, 1'b1} << w_idx;

`ifdef MUX_SEL_LOCK_EN
  assign w_relock = lock & req[r_sel];
`else
  assign w_relock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(DEPTH - 1);
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_idx;
            r_grant <= w_idx_oh;
          end
        end
        GRANT: begin
          // A locked transfer leaves pointer, sel and grant untouched.
          if (out_ready && !w_relock) begin
            r_ptr <= r_sel;
            if (w_found) begin
              r_sel   <= w_idx;
              r_grant <= w_idx_oh;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign sel_valid = (r_state == GRANT);
  assign busy      = (r_state == GRANT);
  assign grant     = r_grant;

endmodule

// File: tb/tb_mux_sel_rr_gen.sv
// Bench for mux_sel_rr_gen: directed scenarios plus randomized traffic against a behavioural round-robin model.
module tb_mux_sel_rr_gen;
  localparam int DEPTH = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DEPTH-1:0] req = '0;
  logic             out_ready = 1'b0;
  logic             lock = 1'b0;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [DEPTH-1:0] grant;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: current grant (valid + index) and last-transferred pointer.
  int m_valid = 0;
  int m_sel   = 0;
  int m_ptr   = DEPTH - 1;

  always #5 clk = ~clk;

  mux_sel_rr_gen #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
`ifdef MUX_SEL_LOCK_EN
    .lock      (lock),
`endif
    .sel       (sel),
    .sel_valid (sel_valid),
    .grant     (grant),
    .busy      (busy)
  );

  function automatic int winner(input logic [DEPTH-1:0] r, input int p);
    for (int k = 1; k <= DEPTH; k++) begin
      if (r[(p + k) % DEPTH]) return (p + k) % DEPTH;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    int w;
    bit lk;
    if (!rst) begin
      m_valid = 0;
      m_sel   = 0;
      m_ptr   = DEPTH - 1;
    end else begin
`ifdef MUX_SEL_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      if (m_valid != 0) begin
        if (out_ready && !(lk && req[m_sel])) begin
          m_ptr = m_sel;
          w = winner(req, m_ptr);
          if (w >= 0) m_sel = w;
          else m_valid = 0;
        end
      end else begin
        w = winner(req, m_ptr);
        if (w >= 0) begin
          m_valid = 1;
          m_sel   = w;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_grant;
    if (chk_en && rst) begin
      exp_grant = (m_valid != 0) ? (32'd1 << m_sel) : 32'd0;
      check("cmp_valid", {31'd0, sel_valid}, (m_valid != 0) ? 32'd1 : 32'd0);
      check("cmp_busy", {31'd0, busy}, (m_valid != 0) ? 32'd1 : 32'd0);
      check("cmp_grant", {16'd0, grant}, exp_grant);
      if (m_valid != 0) check("cmp_sel", {28'd0, sel}, m_sel);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Pins both the DUT and the model to a hand-computed selection.
  task automatic expect_sel(input string name, input int exp);
    check({name, "_valid"}, {31'd0, sel_valid}, 32'd1);
    check({name, "_sel"}, {28'd0, sel}, exp);
    check({name, "_grant"}, {16'd0, grant}, 32'd1 << exp);
    check({name, "_model"}, m_sel, exp);
  endtask

  initial begin
    // 1: reset values and first-grant latency
    #12;
    check("rst_sel", {28'd0, sel}, 0);
    check("rst_valid", {31'd0, sel_valid}, 0);
    check("rst_grant", {16'd0, grant}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    step();
    rst = 1'b1;
    chk_en = 1'b1;
    step();
    check("idle_valid", {31'd0, sel_valid}, 0);
    req = 16'h0001;
    step();
    expect_sel("first", 0);

    // 2: full rotation with wrap
    req = 16'hFFFF;
    out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      expect_sel("rr", i % DEPTH);
    end

    // 3: hold under backpressure, then one transfer
    req = 16'h0024;
    step();
    expect_sel("bp_first", 2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 16'h0024 : 16'h8001;
      step();
      expect_sel("bp_hold", 2);
    end
    req = 16'h0024;
    out_ready = 1'b1;
    step();
    expect_sel("bp_next", 5);

    // 4: wrap skip from ptr=14
    req = 16'h4000;
    step();
    expect_sel("wrap_14", 14);
    req = 16'h0009;
    step();
    expect_sel("wrap_0", 0);
    step();
    expect_sel("wrap_3", 3);

    // 5: dropped request keeps its grant; async reset mid-cycle
    req = 16'h0080;
    step();
    expect_sel("drop_7", 7);
    req = 16'h0000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_sel("drop_hold", 7);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, sel_valid}, 0);
    check("arst_grant", {16'd0, grant}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    step();
    req = 16'h0080;
    rst = 1'b1;
    step();
    expect_sel("after_rst", 7);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
        2: req = DEPTH'($urandom) & DEPTH'($urandom);
        default: req = DEPTH'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_SEL_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    lock = 1'b0;

`ifdef MUX_SEL_LOCK_EN
    // 6: lock re-grants the same requester
    rst = 1'b0;
    out_ready = 1'b0;
    req = 16'h0006;
    step();
    rst = 1'b1;
    step();
    expect_sel("lock_first", 1);
    out_ready = 1'b1;
    lock = 1'b1;
    step();
    expect_sel("lock_hold", 1);
    lock = 1'b0;
    step();
    expect_sel("lock_release", 2);
`endif

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
